// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage definitions: state encoding, reset PC, instruction width
// and the word-alignment helper used for redirect targets.
package instr_fetch_unit_pkg;

  localparam int unsigned        INSTR_W          = 32;
  localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Holds an instruction word that arrived while IF/ID was stalled.
module fetch_hold_buffer
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] data_in,
  output logic [INSTR_W-1:0] data_out
);

  logic [INSTR_W-1:0] word_r;

  // buffer register; clear wins over load so a redirect always drops the word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_r <= NOP_WORD;
    end else if (clear) begin
      word_r <= NOP_WORD;
    end else if (load) begin
      word_r <= data_in;
    end
  end

  assign data_out = word_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC ownership, single-outstanding imem requests,
// stall/redirect handling and the producer side of the IF/ID register.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] next_pc_o,
  output logic [31:0] instruction_o,
  output logic        update_o,
  output logic        flush_n_o,
  output logic [31:0] pc_o
);

  fetch_state_e       state_r, state_s;
  logic [31:0]        pc_r, pc_s, pc_plus4_s, next_pc_r;
  logic [INSTR_W-1:0] instruction_r, deliver_word_s, hold_word_s;
  logic               update_r, flush_n_r;
  logic               deliver_s, flush_s, hold_load_s, hold_clear_s;

  assign pc_plus4_s = pc_r + 32'd4;

  fetch_hold_buffer u_hold (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (hold_load_s),
    .clear    (hold_clear_s),
    .data_in  (imem_rdata_i),
    .data_out (hold_word_s)
  );

  // next state, next pc and delivery decision; a redirect overrides everything
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    deliver_s      = 1'b0;
    deliver_word_s = imem_rdata_i;
    flush_s        = 1'b0;
    hold_load_s    = 1'b0;
    hold_clear_s   = 1'b0;
    if (redirect_i) begin
      pc_s         = word_align(redirect_pc_i);
      flush_s      = 1'b1;
      hold_clear_s = 1'b1;
      case (state_r)
        ST_FETCH:         state_s = ST_DROP;
        ST_WAIT, ST_DROP: state_s = imem_valid_i ? ST_FETCH : ST_DROP;
        ST_HOLD:          state_s = ST_FETCH;
        default:          state_s = ST_FETCH;
      endcase
    end else begin
      case (state_r)
        ST_FETCH: state_s = ST_WAIT;
        ST_WAIT: begin
          if (imem_valid_i && !stall_i) begin
            deliver_s = 1'b1;
            pc_s      = pc_plus4_s;
            state_s   = ST_FETCH;
          end else if (imem_valid_i) begin
            hold_load_s = 1'b1;
            state_s     = ST_HOLD;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            deliver_s      = 1'b1;
            deliver_word_s = hold_word_s;
            pc_s           = pc_plus4_s;
            state_s        = ST_FETCH;
          end else begin
            state_s = ST_HOLD;
          end
        end
        ST_DROP: state_s = imem_valid_i ? ST_FETCH : ST_DROP;
        default: state_s = ST_FETCH;
      endcase
    end
  end

  // state, pc and IF/ID-facing output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r       <= ST_FETCH;
      pc_r          <= RESET_PC;
      next_pc_r     <= 32'd0;
      instruction_r <= NOP_WORD;
      update_r      <= 1'b0;
      flush_n_r     <= 1'b1;
    end else begin
      state_r   <= state_s;
      pc_r      <= pc_s;
      update_r  <= deliver_s;
      flush_n_r <= ~flush_s;
      if (deliver_s) begin
        next_pc_r     <= pc_plus4_s;
        instruction_r <= deliver_word_s;
      end
    end
  end

  assign imem_req_o    = (state_r == ST_FETCH);
  assign imem_addr_o   = pc_r;
  assign next_pc_o     = next_pc_r;
  assign instruction_o = instruction_r;
  assign update_o      = update_r;
  assign flush_n_o     = flush_n_r;
  assign pc_o          = pc_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory model, directed and random
// stall/redirect stimulus, and a monitor comparing against an address-stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] next_pc_o;
  logic [31:0] instruction_o;
  logic        update_o;
  logic        flush_n_o;
  logic [31:0] pc_o;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_valid_i  (imem_valid_i),
    .imem_rdata_i  (imem_rdata_i),
    .next_pc_o     (next_pc_o),
    .instruction_o (instruction_o),
    .update_o      (update_o),
    .flush_n_o     (flush_n_o),
    .pc_o          (pc_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int n_upd = 0;
  bit free_run = 1'b0;

  // stimulus knobs
  int unsigned lat_min = 1, lat_max = 1;
  bit rand_stall = 0, rand_redir = 0;
  bit stall_on_resp = 0, redir_on_resp = 0, redir_in_hold = 0, redir_now = 0;
  bit rst_next = 1'b1;
  bit req_seen = 1'b0;
  logic [31:0] redir_target = 32'd0;
  int stall_hold_cnt = 0;

  // memory model state
  bit          mem_pending = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;

  // scoreboard: redirect targets the DUT must show on pc_o with its flush pulse
  logic [31:0] flush_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic fire(input logic [31:0] tgt);
    redirect_i    = 1'b1;
    redirect_pc_i = tgt;
    flush_q.push_back({tgt[31:2], 2'b00});
  endtask

  // one clock cycle of stimulus: memory response, request capture, stall, redirect
  task automatic step();
    bit rst_was;
    bit fire_s;
    @(posedge clk_i);
    rst_was = rst_i;
    #1;
    rst_i        = rst_next;
    imem_valid_i = 1'b0;
    if (rst_was) begin
      mem_pending = 0;
    end else if (mem_pending) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_valid_i = 1'b1;
        imem_rdata_i = mem_word(mem_addr);
        mem_pending  = 0;
      end
    end
    req_seen = imem_req_o && !rst_i;
    if (req_seen) begin
      check("one_outstanding", {31'd0, mem_pending}, 32'd0);
      mem_pending = 1;
      mem_cnt     = int'($urandom_range(lat_max, lat_min));
      mem_addr    = imem_addr_o;
    end
    fire_s = 1'b0;
    if (stall_hold_cnt > 0) begin
      stall_i = 1'b1;
      stall_hold_cnt--;
      if (stall_hold_cnt == 1 && redir_in_hold) begin
        fire_s        = 1'b1;
        redir_in_hold = 0;
      end
    end else if (stall_on_resp && imem_valid_i) begin
      stall_i        = 1'b1;
      stall_hold_cnt = 2;
      stall_on_resp  = 0;
    end else begin
      stall_i = rand_stall && ($urandom_range(0, 3) == 0);
    end
    redirect_i = 1'b0;
    if (redir_on_resp && imem_valid_i) begin
      fire_s        = 1'b1;
      redir_on_resp = 0;
    end
    if (redir_now) begin
      fire_s    = 1'b1;
      redir_now = 0;
    end
    if (rand_redir && $urandom_range(0, 24) == 0) begin
      fire_s       = 1'b1;
      redir_target = $urandom;
    end
    if (fire_s && !rst_i) fire(redir_target);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40; i++) begin
      step();
      if (req_seen) return;
    end
    check(name, 32'd0, 32'd1);
  endtask

  // monitor: reset values, flush pulses, delivered words and request addresses
  initial begin
    bit          rst_prev = 1'b1;
    bit          exp_flush = 1'b0;
    bit          exp_req_next = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] req_pc = RST_PC;
    logic [31:0] del_pc = RST_PC;
    logic [31:0] tgt;
    int          mcyc = 0;
    int          last_req = -1;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i);
      mcyc++;
      if (rst_prev) begin
        check("rst_update", {31'd0, update_o}, 32'd0);
        check("rst_flush_n", {31'd0, flush_n_o}, 32'd1);
        check("rst_next_pc", next_pc_o, 32'd0);
        check("rst_instruction", instruction_o, 32'd0);
        check("rst_pc", pc_o, RST_PC);
        check("rst_imem_addr", imem_addr_o, RST_PC);
        check("rst_imem_req", {31'd0, imem_req_o}, 32'd1);
        req_pc = RST_PC;
        del_pc = RST_PC;
        flush_q.delete();
      end else begin
        check("flush_timing", {31'd0, flush_n_o}, {31'd0, !exp_flush});
        if (!flush_n_o && flush_q.size() > 0) begin
          tgt = flush_q.pop_front();
          check("pc_after_redirect", pc_o, tgt);
        end
        if (exp_req_next) check("req_after_coincident_redirect", {31'd0, imem_req_o}, 32'd1);
        if (update_o) begin
          check("next_pc", next_pc_o, del_pc + 32'd4);
          check("instruction", instruction_o, mem_word(del_pc));
          check("update_with_flush", {31'd0, flush_n_o}, 32'd1);
          check("update_after_stall", {31'd0, stall_prev}, 32'd0);
          check("update_with_req", {31'd0, imem_req_o}, 32'd1);
          del_pc = del_pc + 32'd4;
          n_upd++;
        end
      end
      if (!rst_i && imem_req_o) begin
        check("req_addr", imem_addr_o, req_pc);
        req_pc = req_pc + 32'd4;
        if (free_run && last_req >= 0) check("req_interval", 32'(mcyc - last_req), 32'd2);
        last_req = mcyc;
      end
      if (rst_i) last_req = -1;
      exp_flush    = 1'b0;
      exp_req_next = 1'b0;
      if (!rst_i && redirect_i) begin
        exp_flush    = 1'b1;
        exp_req_next = imem_valid_i;
        req_pc       = {redirect_pc_i[31:2], 2'b00};
        del_pc       = {redirect_pc_i[31:2], 2'b00};
      end
      rst_prev   = rst_i;
      stall_prev = stall_i;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset then free run at L=1
    run(3);
    rst_next = 1'b0;
    free_run = 1'b1;
    run(12);
    free_run = 1'b0;
    check("free_run_updates", {31'd0, n_upd >= 3}, 32'd1);

    // stall for 3 cycles starting at a response
    stall_on_resp = 1;
    run(14);

    // redirect in WAIT one cycle after a request, L=3
    lat_min = 3; lat_max = 3;
    wait_req("timeout_req_wait_redirect");
    redir_target = 32'h0000_0103;
    redir_now    = 1;
    run(16);

    // redirect coincident with a response, L=2
    lat_min = 2; lat_max = 2;
    redir_target  = $urandom;
    redir_on_resp = 1;
    run(14);

    // redirect while stalled in HOLD, target exercises pc wrap
    lat_min = 1; lat_max = 1;
    redir_target  = 32'hFFFF_FFFC;
    stall_on_resp = 1;
    redir_in_hold = 1;
    run(16);

    // synchronous reset while in DROP
    lat_min = 6; lat_max = 6;
    wait_req("timeout_req_drop_reset");
    redir_target = 32'h0000_2000;
    redir_now    = 1;
    step();
    rst_next = 1'b1;
    step();
    rst_next = 1'b0;
    run(12);

    // randomized traffic
    lat_min = 1; lat_max = 4;
    rand_stall = 1; rand_redir = 1;
    run(800);
    rand_stall = 0; rand_redir = 0;
    stall_i = 1'b0;
    run(30);
    check("flush_q_drained", flush_q.size(), 32'd0);
    check("total_updates", {31'd0, n_upd > 60}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the 5-stage pipelined CPU: owns the program counter, issues single-outstanding requests to a variable-latency instruction memory, and is the producer side of the IF/ID pipeline register. It delivers `{next_pc, instruction}` with an `update` strobe and an active-low `flush` bubble. It honours stall and branch-redirect requests from the hazard/branch logic, and discards in-flight responses on a redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `stall_i`  in  1  IF/ID must hold; no new instruction delivered.
- `redirect_i`  in  1  taken branch/jump; restart fetch at `redirect_pc_i`.
- `redirect_pc_i`  in  32  redirect target; bits [1:0] forced to 0.
- `imem_req_o`  out  1  one-cycle request pulse; memory always accepts.
- `imem_addr_o`  out  32  request address, valid when `imem_req_o`=1.
- `imem_valid_i`  in  1  response strobe, ≥1 cycle after its request.
- `imem_rdata_i`  in  32  instruction word, valid with `imem_valid_i`.
- `next_pc_o`  out  32  PC+4 of delivered instruction, feeds IF/ID `next_pc`.
- `instruction_o`  out  32  delivered instruction, feeds IF/ID `instruction`.
- `update_o`  out  1  one-cycle strobe: load IF/ID with the outputs above.
- `flush_n_o`  out  1  active-low, one-cycle: clear IF/ID to zero.
- `pc_o`  out  32  current fetch PC (debug).

## Operation
- **States:** FETCH, WAIT, HOLD, DROP.
- **FETCH:** `imem_req_o`=1, `imem_addr_o`=pc. Goes to WAIT next cycle.
- **WAIT:** one request outstanding.
  - On `imem_valid_i` with `stall_i`=0: register `instruction_o`=rdata, `next_pc_o`=pc+4, `update_o`=1. Then pc←pc+4 and go to FETCH.
  - On `imem_valid_i` with `stall_i`=1: capture rdata into the hold buffer and go to HOLD.
- **HOLD:** while `stall_i`=1, stay and keep the buffer. When `stall_i`=0, deliver the buffer as above, then pc←pc+4 and go to FETCH.
- **DROP:** waiting for the response of a cancelled request. On `imem_valid_i`, discard rdata and go to FETCH.
- **Redirect priority:** `redirect_i` beats `stall_i` and delivery. In any state it sets pc←{redirect_pc_i[31:2],2'b00} and `flush_n_o`=0 next cycle; `update_o`=0 that cycle.
  - From FETCH (request issuing this cycle): go to DROP.
  - From WAIT without `imem_valid_i`: go to DROP.
  - From WAIT with `imem_valid_i` in the same cycle: discard the response and go to FETCH.
  - From HOLD: discard the buffer and go to FETCH.
  - From DROP: stay in DROP with the new pc. With `imem_valid_i` in the same cycle: go to FETCH.
- **Stray responses:** `imem_valid_i` in FETCH or HOLD is ignored.
- **Arithmetic:** pc+4 wraps modulo 2^32.

## Timing
- **Reset values:** state=FETCH, pc=`RESET_PC`, `next_pc_o`=0, `instruction_o`=0, `update_o`=0, `flush_n_o`=1, `imem_addr_o`=`RESET_PC`.
  - `imem_req_o` is combinational from state and is 1 in the first cycle after `rst_i` deasserts.
- **Reset mid-operation:** an outstanding request is abandoned. Instruction memory shares `rst_i`, so no stale response follows.
- **Latency:** request at cycle t, response at t+L (L≥1), `update_o` at t+L+1, next request at t+L+1. Steady throughput is one instruction per L+1 cycles.
- `update_o` and `flush_n_o`=0 are never asserted in the same cycle. Each is a single-cycle pulse per event.
- All outputs except `imem_req_o` and `imem_addr_o` are registered.
- `pc_o` reflects the registered pc.

## Structure
- **Shared pipeline package:**
  - 2-bit fetch-state encoding: FETCH=0, WAIT=1, HOLD=2, DROP=3.
  - `RESET_PC` default.
  - Instruction width (32).
  - NOP word 32'h0.
- One natural sub-module: `fetch_hold_buffer`, a 32-bit hold register with load/clear. The pc register and FSM stay in the top.

## Test plan
- **Reset then free run:** memory latency L=1, RESET_PC=0. Required: requests at 0x0, 0x4, 0x8 every 2 cycles; `update_o` pulses with `next_pc_o`=0x4, 0x8, 0xC.
- **Stall on response:** `stall_i`=1 for 3 cycles starting at the response cycle. Required: no `update_o` and no new request during the stall; one `update_o` with the buffered word in the cycle after `stall_i` falls.
- **Redirect in WAIT:** L=3, redirect to 0x0000_0103 one cycle after a request. Required: `flush_n_o`=0 for one cycle; the old response is discarded; the next request address is 0x100.
- **Redirect coincident with response:** Required: no `update_o`; a request to the target is issued the next cycle.
- **Redirect while stalled in HOLD:** Required: the buffer is dropped, `flush_n_o` pulses, and fetch restarts at the target. Also check pc wrap from 0xFFFF_FFFC: `next_pc_o`=0x0.
- **Synchronous reset asserted in DROP:** Required: all outputs return to reset values on the next edge; fetch restarts at `RESET_PC`.
